// File: rtl/modadd_pkg.sv
// Shared definitions for the modular add/subtract datapaths: default width,
// pipeline depth and the generate/propagate combine used by the prefix networks.
package modadd_pkg;

    localparam int WIDTH_DEF  = 4;
    localparam int PIPE_DEPTH = 2;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Black-node operator: (hi) o (lo) for a higher-order span over a lower one.
    function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
        gp_t res;
        res.g = hi.g | (hi.p & lo.g);
        res.p = hi.p & lo.p;
        return res;
    endfunction

endpackage

// File: rtl/prefix_borrow_subtractor.sv
// Combinational WIDTH-bit a - b built on a Kogge-Stone borrow prefix network.
module prefix_borrow_subtractor
    import modadd_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o
);

    localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    gp_t              lv [LEVELS+1][WIDTH];
    logic [WIDTH-1:0] bin;

    // A bit generates a borrow when a=0,b=1 and passes one through when a==b.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            lv[0][i].g = ~a_i[i] & b_i[i];
            lv[0][i].p = ~(a_i[i] ^ b_i[i]);
        end
        for (int k = 0; k < LEVELS; k++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= (1 << k)) begin
                    lv[k+1][i] = gp_combine(lv[k][i], lv[k][i-(1<<k)]);
                end else begin
                    lv[k+1][i] = lv[k][i];
                end
            end
        end
        bin[0] = 1'b0;
        for (int i = 1; i < WIDTH; i++) begin
            bin[i] = lv[LEVELS][i-1].g;
        end
    end

    assign diff_o   = a_i ^ b_i ^ bin;
    assign borrow_o = lv[LEVELS][WIDTH-1].g;

endmodule

// File: rtl/modular_subtractor.sv
// Two-stage pipelined (a - b) mod m with valid/ready on both sides:
// stage 1 registers the raw difference and borrow, stage 2 adds m back on borrow.
module modular_subtractor
    import modadd_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             range_err
);

    logic [WIDTH-1:0] diff;
    logic             borrow;

    logic             vld_p1_q, vld_p1_d;
    logic [WIDTH-1:0] d_p1_q, d_p1_d;
    logic [WIDTH-1:0] m_p1_q, m_p1_d;
    logic             borrow_p1_q, borrow_p1_d;
    logic             err_p1_q, err_p1_d;

    logic             vld_p2_q, vld_p2_d;
    logic [WIDTH-1:0] r_p2_q, r_p2_d;
    logic             err_p2_q, err_p2_d;

    logic             stage2_load;
    logic             in_fire;

    prefix_borrow_subtractor #(.WIDTH(WIDTH)) u_sub (
        .a_i      (a),
        .b_i      (b),
        .diff_o   (diff),
        .borrow_o (borrow)
    );

    // in_ready depends combinationally on out_ready so a full pipe still streams.
    assign stage2_load = vld_p1_q && (!vld_p2_q || out_ready);
    assign in_ready    = !vld_p1_q || stage2_load;
    assign in_fire     = in_valid && in_ready;

    always_comb begin
        vld_p1_d    = vld_p1_q;
        d_p1_d      = d_p1_q;
        m_p1_d      = m_p1_q;
        borrow_p1_d = borrow_p1_q;
        err_p1_d    = err_p1_q;
        if (in_fire) begin
            vld_p1_d    = 1'b1;
            d_p1_d      = diff;
            m_p1_d      = m;
            borrow_p1_d = borrow;
            err_p1_d    = (a >= m) | (b >= m) | (m == '0);
        end else if (stage2_load) begin
            vld_p1_d    = 1'b0;
        end
    end

    // Stage 1 -> stage 2: for legal operands d + m lands in [0, m-1], so truncation is exact.
    always_comb begin
        vld_p2_d = vld_p2_q;
        r_p2_d   = r_p2_q;
        err_p2_d = err_p2_q;
        if (stage2_load) begin
            vld_p2_d = 1'b1;
            err_p2_d = err_p1_q;
            if (err_p1_q) begin
                r_p2_d = '0;
            end else if (borrow_p1_q) begin
                r_p2_d = d_p1_q + m_p1_q;
            end else begin
                r_p2_d = d_p1_q;
            end
        end else if (out_ready) begin
            vld_p2_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q    <= 1'b0;
            d_p1_q      <= '0;
            m_p1_q      <= '0;
            borrow_p1_q <= 1'b0;
            err_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            r_p2_q      <= '0;
            err_p2_q    <= 1'b0;
        end else begin
            vld_p1_q    <= vld_p1_d;
            d_p1_q      <= d_p1_d;
            m_p1_q      <= m_p1_d;
            borrow_p1_q <= borrow_p1_d;
            err_p1_q    <= err_p1_d;
            vld_p2_q    <= vld_p2_d;
            r_p2_q      <= r_p2_d;
            err_p2_q    <= err_p2_d;
        end
    end

    assign out_valid = vld_p2_q;
    assign r         = r_p2_q;
    assign range_err = err_p2_q;

endmodule

// File: doc/modular_subtractor.md
Name: modular_subtractor

Overview:
Pipelined modular subtractor, the subtract-direction counterpart of the modular adder datapath. Computes R = (A − B) mod M for operands already reduced modulo M.
- Stage 1: prefix-network subtract producing difference plus borrow.
- Stage 2: conditional add-back of M.
- Valid/ready handshake on both sides; sits between the operand source and the result consumer in the second-stage datapath.

Parameters:
WIDTH, 4, operand/modulus bit width (legal range 2..16)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand triple valid
in_ready  output  1  block can accept operands this cycle
a  input  WIDTH  minuend, expected < m
b  input  WIDTH  subtrahend, expected < m
m  input  WIDTH  modulus, sampled with a/b per transaction
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result this cycle
r  output  WIDTH  (a − b) mod m
range_err  output  1  transaction had a ≥ m, b ≥ m, or m == 0

Behaviour:
- Reset (async assert, sync release): s1_valid = 0, out_valid = 0, r = 0, range_err = 0, all internal registers 0.
- Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
- Stage 1 register:
  - Captures d = a − b as WIDTH bits, borrow = (a < b), m, err = (a ≥ m) | (b ≥ m) | (m == 0).
  - d and borrow come from a parallel-prefix borrow network: generate = ~a & b, propagate = ~(a ^ b).
  - No ripple chain.
- Stage 2 register (output):
  - r = err ? 0 : (borrow ? d + m truncated to WIDTH : d).
  - range_err = err.
- Advance rules:
  - stage2_load = s1_valid && (!out_valid || out_ready).
  - in_ready = !s1_valid || stage2_load. This is a combinational path from out_ready; it is accepted.
  - On the same edge, stage 1 may load new operands while stage 2 loads from stage 1 (full throughput).
- Latency: 2 cycles from input transfer to out_valid with out_ready held high. Throughput 1 result/cycle.
- Backpressure: with out_ready low, out_valid/r/range_err hold stable. Stage 1 fills, then in_ready drops. Maximum 2 transactions in flight.
- Ordering: strictly in order; no drop, no duplication.
- in_valid low: no state change in stage 1 except draining.
- Reset mid-operation: all in-flight transactions discarded; out_valid falls immediately on rst_n assert.
- Arithmetic boundaries:
  - a == b gives 0.
  - b == m−1, a == 0 gives 1.
  - When borrow is set, d + m always lies in [0, m−1] for legal operands, so truncation is exact.
- range_err transactions still complete and handshake normally, with r = 0.

Decomposition:
- Shared package (modadd_pkg): WIDTH default, pipeline depth constant (2), and the generate/propagate combine function shared with the adder's black-node logic.
- One natural sub-module: prefix_borrow_subtractor. Purely combinational, WIDTH-bit a − b via the prefix network, outputs diff[WIDTH-1:0] and borrow_out.
- The top level holds only the two pipeline registers, handshake logic, and the add-back mux.

Test Plan:
- m=11, a=7, b=3, out_ready=1 → out_valid exactly 2 cycles after transfer, r=4, range_err=0.
- m=11, (a,b) = (3,7), (5,5), (0,10) back-to-back → r = 7, 0, 1 on consecutive cycles, in_ready constantly 1.
- m=15 (WIDTH=4 max), a=0, b=14 → r=1; a=14, b=0 → r=14.
- Backpressure, m=11:
  - Send (7,3) then (3,7) with out_ready=0 → in_ready goes 0 after the 2nd transfer; r=4 held stable.
  - Raise out_ready → r=4 then r=7; in_ready returns 1.
- m=11, a=12, b=3 → range_err=1, r=0. Following m=0 transaction → range_err=1. Following legal transaction → range_err=0.
- Assert rst_n=0 while 2 transactions are in flight → out_valid, r, range_err go 0 asynchronously. After release no stale result appears; in_ready=1.
